// File: rtl/spike_rate_classifier.sv
// Counts layer-2 spikes per neuron over a programmable window, then picks the
// highest-rate neuron with a sequential argmax and holds the result for a consumer.
module spike_rate_classifier #(
  parameter int NUM_NEURONS  = 3,
  parameter int CNT_WIDTH    = 8,
  parameter int WINDOW_WIDTH = 16,
  parameter int IDX_W        = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [WINDOW_WIDTH-1:0]          window_len,
  input  logic [NUM_NEURONS-1:0]           spikes,
  output logic                             busy,
  output logic                             result_valid,
  input  logic                             result_ready,
  output logic [IDX_W-1:0]                 winner_idx,
  output logic [CNT_WIDTH-1:0]             winner_count,
  output logic                             tie,
  output logic                             silent,
  output logic [NUM_NEURONS*CNT_WIDTH-1:0] spike_counts
);

  localparam int SCAN_W = $clog2(NUM_NEURONS + 1);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COUNT   = 2'd1;
  localparam logic [1:0] COMPARE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [1:0]                       state_q, state_d;
  logic [WINDOW_WIDTH-1:0]          win_len_q, win_len_d;
  logic [WINDOW_WIDTH-1:0]          win_cnt_q, win_cnt_d;
  logic [NUM_NEURONS*CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [SCAN_W-1:0]                scan_q, scan_d;
  logic [CNT_WIDTH-1:0]             best_q, best_d;
  logic [IDX_W-1:0]                 best_idx_q, best_idx_d;
  logic                             tie_scan_q, tie_scan_d;
  logic [IDX_W-1:0]                 winner_idx_q, winner_idx_d;
  logic [CNT_WIDTH-1:0]             winner_count_q, winner_count_d;
  logic                             tie_q, tie_d;
  logic                             silent_q, silent_d;
  logic                             valid_q, valid_d;
  logic [CNT_WIDTH-1:0]             cur_cnt;

  always_comb begin
    state_d        = state_q;
    win_len_d      = win_len_q;
    win_cnt_d      = win_cnt_q;
    cnt_d          = cnt_q;
    scan_d         = scan_q;
    best_d         = best_q;
    best_idx_d     = best_idx_q;
    tie_scan_d     = tie_scan_q;
    winner_idx_d   = winner_idx_q;
    winner_count_d = winner_count_q;
    tie_d          = tie_q;
    silent_d       = silent_q;
    valid_d        = valid_q;
    cur_cnt        = cnt_q[int'(scan_q)*CNT_WIDTH +: CNT_WIDTH];
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d        = COUNT;
          win_len_d      = (window_len == '0) ? WINDOW_WIDTH'(1) : window_len;
          win_cnt_d      = '0;
          cnt_d          = '0;
          winner_idx_d   = '0;
          winner_count_d = '0;
          tie_d          = 1'b0;
          silent_d       = 1'b0;
        end
      end
      COUNT: begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
          if (spikes[i] && cnt_q[i*CNT_WIDTH +: CNT_WIDTH] != CNT_MAX)
            cnt_d[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i*CNT_WIDTH +: CNT_WIDTH] + 1'b1;
        end
        win_cnt_d = win_cnt_q + 1'b1;
        if (win_cnt_q == win_len_q - 1'b1) begin
          state_d = COMPARE;
          scan_d  = '0;
        end
      end
      COMPARE: begin
        // One extra edge after the last index publishes the scan result.
        if (scan_q == SCAN_W'(NUM_NEURONS)) begin
          winner_idx_d   = best_idx_q;
          winner_count_d = best_q;
          tie_d          = tie_scan_q;
          silent_d       = (best_q == '0);
          valid_d        = 1'b1;
          state_d        = DONE;
        end else begin
          if (scan_q == '0) begin
            best_d     = cur_cnt;
            best_idx_d = '0;
            tie_scan_d = 1'b0;
          end else if (cur_cnt > best_q) begin
            best_d     = cur_cnt;
            best_idx_d = IDX_W'(scan_q);
            tie_scan_d = 1'b0;
          end else if (cur_cnt == best_q) begin
            tie_scan_d = 1'b1;
          end
          scan_d = scan_q + 1'b1;
        end
      end
      default: begin
        if (result_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      win_len_q      <= '0;
      win_cnt_q      <= '0;
      cnt_q          <= '0;
      scan_q         <= '0;
      best_q         <= '0;
      best_idx_q     <= '0;
      tie_scan_q     <= 1'b0;
      winner_idx_q   <= '0;
      winner_count_q <= '0;
      tie_q          <= 1'b0;
      silent_q       <= 1'b0;
      valid_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      win_len_q      <= win_len_d;
      win_cnt_q      <= win_cnt_d;
      cnt_q          <= cnt_d;
      scan_q         <= scan_d;
      best_q         <= best_d;
      best_idx_q     <= best_idx_d;
      tie_scan_q     <= tie_scan_d;
      winner_idx_q   <= winner_idx_d;
      winner_count_q <= winner_count_d;
      tie_q          <= tie_d;
      silent_q       <= silent_d;
      valid_q        <= valid_d;
    end
  end

  assign busy         = (state_q == COUNT) || (state_q == COMPARE);
  assign result_valid = valid_q;
  assign winner_idx   = winner_idx_q;
  assign winner_count = winner_count_q;
  assign tie          = tie_q;
  assign silent       = silent_q;
  assign spike_counts = cnt_q;

endmodule
